// File: rtl/freq_gen_pkg.sv
// Shared constants and types for the square-wave tone generator.
//   CNT_W        : default threshold/counter width
//   CLK_HZ       : nominal system clock (internal oscillator)
//   fg_state_t   : generator FSM states
//   NOTE_*       : half-period thresholds for common notes at CLK_HZ
//   note_threshold(): threshold for a tone frequency, rounded to nearest
package freq_gen_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned CLK_HZ = 48_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fg_state_t;

  localparam int unsigned NOTE_A4 = 54544;
  localparam int unsigned NOTE_C5 = 45866;
  localparam int unsigned NOTE_A5 = 27272;

  // CLK_HZ/(2*hz) - 1, rounded so the generated tone lands closest to hz.
  function automatic int unsigned note_threshold(input int unsigned hz);
    return ((CLK_HZ + hz) / (2 * hz)) - 1;
  endfunction

endpackage

// File: rtl/half_period_counter.sv
// Half-period counter for freq_generator.
// Holds the running count and the shadow copy of the threshold, and flags
// the half-period boundary.
//   clk, rst   : clock, asynchronous active-high reset
//   run        : counting enabled (generator running and enabled)
//   reload     : while not running, keep shadow tracking threshold
//   threshold  : requested half-period length minus one
//   boundary   : combinational strobe, high when the current half-period ends
module half_period_counter #(
  parameter int unsigned CNT_W = freq_gen_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             reload,
  input  logic [CNT_W-1:0] threshold,
  output logic             boundary
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] shadow;
  logic             hit;

  // Equality only: count never passes shadow, so no wrap even at all-ones.
  assign hit      = (count == shadow);
  assign boundary = run && hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      shadow <= '0;
    end else if (!run) begin
      count <= '0;
      if (reload) begin
        shadow <= threshold;
      end
    end else if (hit) begin
      // New threshold is only picked up here, so a half-period never gets cut short.
      count  <= '0;
      shadow <= threshold;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/freq_generator.sv
// Square-wave tone generator for the speaker PWM pin.
// Produces a 50 % duty square wave whose half-period is threshold+1 clocks.
//   clk        : system clock (48 MHz internal oscillator)
//   reset      : asynchronous active-high reset
//   en         : tone enable; low forces pwm low (silence)
//   threshold  : half-period length minus one, in clk cycles
//   pwm        : square-wave output
//   tick       : one-cycle pulse after every pwm toggle
//                (only when FREQGEN_TICK_EN is defined)
module freq_generator #(
  parameter int unsigned CNT_W = freq_gen_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] threshold,
  output logic             pwm
`ifdef FREQGEN_TICK_EN
  ,
  output logic             tick
`endif
);

  import freq_gen_pkg::*;

  fg_state_t state, state_d;
  logic      pwm_d;
  logic      boundary;
  logic      run;

  assign run = (state == RUN) && en;

  half_period_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst       (reset),
    .run       (run),
    .reload    (state == IDLE),
    .threshold (threshold),
    .boundary  (boundary)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pwm   <= 1'b0;
    end else begin
      state <= state_d;
      pwm   <= pwm_d;
    end
  end

  always_comb begin
    state_d = state;
    pwm_d   = pwm;
    case (state)
      IDLE: begin
        pwm_d = 1'b0;
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Disable wins over a coincident boundary: stop low, no final toggle.
        if (!en) begin
          state_d = IDLE;
          pwm_d   = 1'b0;
        end else if (boundary) begin
          pwm_d = ~pwm;
        end
      end
      default: begin
        state_d = IDLE;
        pwm_d   = 1'b0;
      end
    endcase
  end

`ifdef FREQGEN_TICK_EN
  // boundary only fires while running and enabled, so tick stays low in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= 1'b0;
    end else begin
      tick <= boundary;
    end
  end
`endif

endmodule

// File: tb/tb_freq_generator.sv
module tb_freq_generator;

  localparam int unsigned CNT_W = 32;

  typedef struct {
    int unsigned cyc;
    logic        val;
    logic        tk;
  } ev_t;

  logic             clk;
  logic             reset;
  logic             en;
  logic [CNT_W-1:0] threshold;
  logic             pwm;
`ifdef FREQGEN_TICK_EN
  logic             tick;
`endif

  freq_generator #(
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .threshold (threshold),
    .pwm       (pwm)
`ifdef FREQGEN_TICK_EN
    ,
    .tick      (tick)
`endif
  );

  int unsigned cyc;
  int          n_cmp;
  int          n_bad;
  ev_t         exp_q[$];
  bit          done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = number of rising edges seen so far
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int unsigned c, input logic v, input logic t);
    ev_t e;
    e.cyc = c;
    e.val = v;
    e.tk  = t;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every pwm change is an output event, popped against the scoreboard.
  initial begin : monitor
    logic prev_pwm;
    ev_t  e;
    prev_pwm = 1'b0;
    forever begin
      @(negedge clk);
      if (pwm !== prev_pwm) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_toggle: edge %0d pwm=%b, required no change", cyc, pwm);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (cyc != e.cyc || pwm !== e.val) begin
            n_bad++;
            $display("FAIL toggle: edge %0d pwm=%b, required edge %0d pwm=%b",
                     cyc, pwm, e.cyc, e.val);
          end
`ifdef FREQGEN_TICK_EN
          n_cmp++;
          if (tick !== e.tk) begin
            n_bad++;
            $display("FAIL tick_at_toggle: edge %0d tick=%b, required %b", cyc, tick, e.tk);
          end
`endif
        end
      end else begin
`ifdef FREQGEN_TICK_EN
        n_cmp++;
        if (tick !== 1'b0) begin
          n_bad++;
          $display("FAIL tick_idle: edge %0d tick=%b, required 0", cyc, tick);
        end
`endif
      end
      prev_pwm = pwm;
    end
  end

  initial begin : watchdog
    #1_000_000;
    if (!done) begin
      $display("FAIL watchdog: time limit reached with %0d events outstanding, required 0",
               exp_q.size());
      $fatal(1, "watchdog");
    end
  end

  initial begin : stim
    int unsigned e0;
    int unsigned e1;
    int unsigned r;
    done      = 1'b0;
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    en        = 1'b0;
    threshold = '0;

    // Reset held, then released with en low: silence.
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pwm !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pwm: pwm=%b, required 0", pwm);
    end
`ifdef FREQGEN_TICK_EN
    n_cmp++;
    if (tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_tick: tick=%b, required 0", tick);
    end
`endif
    reset = 1'b0;
    wait_cyc(cyc + 20);
    n_cmp++;
    if (pwm !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_pwm: pwm=%b, required 0", pwm);
    end

    // threshold 0: toggle every edge; then drop en while high.
    threshold = 32'd0;
    en        = 1'b1;
    e0 = cyc + 1;
    for (int unsigned k = 1; k <= 11; k++) push(e0 + k, logic'(k[0]), 1'b1);
    wait_cyc(e0 + 11);
    en = 1'b0;
    push(e0 + 12, 1'b0, 1'b0);
    wait_cyc(e0 + 14);

    // threshold 3, switched to 7 mid half-period.
    threshold = 32'd3;
    en        = 1'b1;
    e0 = cyc + 1;
    push(e0 + 4,  1'b1, 1'b1);
    push(e0 + 12, 1'b0, 1'b1);
    push(e0 + 20, 1'b1, 1'b1);
    wait_cyc(e0 + 1);
    threshold = 32'd7;
    // en dropped mid high phase, then raised again.
    wait_cyc(e0 + 23);
    en = 1'b0;
    push(e0 + 24, 1'b0, 1'b0);
    wait_cyc(e0 + 26);
    en = 1'b1;
    e1 = e0 + 27;
    push(e1 + 8, 1'b1, 1'b1);
    wait_cyc(e1 + 10);

    // Async reset pulse between edges while pwm is high.
    r = cyc;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (pwm !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_pwm: pwm=%b, required 0", pwm);
    end
    #1 reset = 1'b0;
    push(r + 1, 1'b0, 1'b0);
    push(r + 1 + 8, 1'b1, 1'b1);
    wait_cyc(r + 11);
    en = 1'b0;
    push(r + 12, 1'b0, 1'b0);
    wait_cyc(r + 14);

    // A5: high for 27273 cycles after a 27273-cycle low lead-in.
    threshold = 32'd27272;
    en        = 1'b1;
    e0 = cyc + 1;
    push(e0 + 27273, 1'b1, 1'b1);
    push(e0 + 54546, 1'b0, 1'b1);
    wait_cyc(e0 + 54547);
    en = 1'b0;
    wait_cyc(cyc + 5);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_toggle: no pwm change seen, required edge %0d pwm=%b", e.cyc, e.val);
    end
    n_cmp++;
    if (pwm !== 1'b0) begin
      n_bad++;
      $display("FAIL final_pwm: pwm=%b, required 0", pwm);
    end

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
